// File: rtl/ftdi_fifo_avalon_st_instream.sv
`timescale 1ns/1ps
// ftdi_fifo_avalon_st_instream
// Receive bridge from an FT245-style asynchronous FIFO to an Avalon-ST source.
// Senses RXF#, issues timed RD# strobes, captures each byte into a 2-entry
// in-order buffer and presents the head as an Avalon-ST stream (ready latency 0).
// Ports:
//   clk, rst         system clock, asynchronous active-low reset
//   oST_VALID        Avalon-ST valid (buffer not empty)
//   oST_DATA[7:0]    Avalon-ST data (buffer head)
//   iST_READY        Avalon-ST ready
//   iFIFO_RXF_n      FTDI data-available, active-low, asynchronous
//   oFIFO_RD_n       FTDI read strobe, active-low, registered
//   iFIFO_DATA[7:0]  FTDI data bus (input direction only)
//   oFIFO_OE_n       bus output enable, tied high: this block never drives the bus
module ftdi_fifo_avalon_st_instream #(
  parameter int unsigned RD_PULSE_CYCLES     = 3,
  parameter int unsigned RD_PRECHARGE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       oST_VALID,
  output logic [7:0] oST_DATA,
  input  logic       iST_READY,
  input  logic       iFIFO_RXF_n,
  output logic       oFIFO_RD_n,
  input  logic [7:0] iFIFO_DATA,
  output logic       oFIFO_OE_n
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_MAX = (RD_PULSE_CYCLES > RD_PRECHARGE_CYCLES) ?
                                    RD_PULSE_CYCLES : RD_PRECHARGE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned OCC_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_PRECHARGE = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    tmr, tmr_d;
  logic                rd_n_d;
  logic                push_c;
  logic                pop_c;
  logic                rxf_s;
  logic [1:0]          rxf_sync;
  logic [OCC_W-1:0]    count;
  logic [DATA_W-1:0]   tail_q;

  assign oFIFO_OE_n = 1'b1;

  // RXF# synchronizer; idles high so nothing launches during refill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rxf_sync <= 2'b11;
    else      rxf_sync <= {rxf_sync[0], iFIFO_RXF_n};
  end
  assign rxf_s = rxf_sync[1];

  // State register, strobe timer and registered RD#
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      oFIFO_RD_n <= 1'b1;
    end else begin
      state      <= state_d;
      tmr        <= tmr_d;
      oFIFO_RD_n <= rd_n_d;
    end
  end

  // Next-state logic; a read is only launched when the buffer has room
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:      if (!rxf_s && (count < OCC_W'(2))) state_d = ST_READ;
      ST_READ:      if (tmr == '0) state_d = ST_PRECHARGE;
      ST_PRECHARGE: if (tmr == '0) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output / timer logic: next RD# level, timer reload and capture pulse
  always_comb begin
    rd_n_d = 1'b1;
    tmr_d  = tmr;
    push_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxf_s && (count < OCC_W'(2))) begin
          rd_n_d = 1'b0;
          tmr_d  = CNT_W'(RD_PULSE_CYCLES - 1);
        end
      end
      ST_READ: begin
        if (tmr == '0) begin
          push_c = 1'b1;
          tmr_d  = CNT_W'(RD_PRECHARGE_CYCLES - 1);
        end else begin
          rd_n_d = 1'b0;
          tmr_d  = tmr - CNT_W'(1);
        end
      end
      ST_PRECHARGE: begin
        if (tmr != '0) tmr_d = tmr - CNT_W'(1);
      end
      default: begin
        tmr_d = '0;
      end
    endcase
  end

  assign pop_c = oST_VALID & iST_READY;

  // Two-entry output buffer; oST_DATA is the head register itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      oST_VALID <= 1'b0;
      oST_DATA  <= '0;
      tail_q    <= '0;
    end else begin
      case ({push_c, pop_c})
        2'b10: begin
          if (count == '0) oST_DATA <= iFIFO_DATA;
          else             tail_q   <= iFIFO_DATA;
          count     <= count + OCC_W'(1);
          oST_VALID <= 1'b1;
        end
        2'b01: begin
          oST_DATA  <= tail_q;
          count     <= count - OCC_W'(1);
          oST_VALID <= (count != OCC_W'(1));
        end
        2'b11: begin
          // occupancy unchanged; the new byte lands behind whatever remains
          if (count == OCC_W'(1)) begin
            oST_DATA <= iFIFO_DATA;
          end else begin
            oST_DATA <= tail_q;
            tail_q   <= iFIFO_DATA;
          end
          oST_VALID <= 1'b1;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule
